// File: rtl/ulpb_tx_arbiter_pkg.sv
// Shared widths and arbiter state encoding for the ulpb TX arbiter.
package ulpb_tx_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReqHi = 3'd1,
        StReqLo = 3'd2,
        StNext  = 3'd3,
        StResp  = 3'd4,
        StClr   = 3'd5
    } arb_state_e;

endpackage

// File: rtl/ulpb_rr_pick.sv
// Combinational rotate-priority picker: first valid bit at or after ptr_i, wrapping.
module ulpb_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int unsigned j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!any_o && valid_i[j]) begin
                any_o       = 1'b1;
                idx_o       = IW'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ulpb_tx_arbiter.sv
// Round-robin arbiter sharing one ulpb node TX port between NUM_REQ requesters,
// with message locking, four-phase TX handshake and retry of failed single-word messages.
module ulpb_tx_arbiter
    import ulpb_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned RETRY_LIMIT = 2
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_PEND,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    output logic [NUM_REQ-1:0]            REQ_DONE,
    output logic [NUM_REQ-1:0]            REQ_FAIL,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_PEND,
    output logic                          TX_REQ,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic                          TX_RESP_ACK
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(RETRY_LIMIT + 2);

    arb_state_e              state_q, state_d;
    logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]         grant_q, grant_d;
    logic [NUM_REQ-1:0]      grant_oh_q, grant_oh_d;
    logic [CntW-1:0]         retry_cnt_q, retry_cnt_d;
    logic                    retry_q, retry_d;
    logic                    multi_q, multi_d;
    logic [ADDR_WIDTH-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    hold_pend_q, hold_pend_d;
    logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]      req_done_q, req_done_d;
    logic [NUM_REQ-1:0]      req_fail_q, req_fail_d;

    logic [NUM_REQ-1:0]      pick_oh;
    logic [IdxW-1:0]         pick_idx;
    logic                    pick_any;

    ulpb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IdxW)
    ) u_pick (
        .valid_i  (REQ_VALID),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        grant_oh_d  = grant_oh_q;
        retry_cnt_d = retry_cnt_q;
        retry_d     = retry_q;
        multi_d     = multi_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        hold_pend_d = hold_pend_q;
        req_ack_d   = '0;
        req_done_d  = '0;
        req_fail_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d     = pick_idx;
                    grant_oh_d  = pick_oh;
                    hold_addr_d = REQ_ADDR[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    hold_data_d = REQ_DATA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    hold_pend_d = REQ_PEND[pick_idx];
                    multi_d     = REQ_PEND[pick_idx];
                    retry_cnt_d = '0;
                    retry_d     = 1'b0;
                    state_d     = StReqHi;
                end
            end
            StReqHi: begin
                if (TX_FAIL) begin
                    state_d = StResp;
                end else if (TX_ACK) begin
                    req_ack_d = grant_oh_q;
                    state_d   = StReqLo;
                end
            end
            StReqLo: begin
                if (TX_FAIL) begin
                    state_d = StResp;
                end else if (!TX_ACK) begin
                    state_d = hold_pend_q ? StNext : StResp;
                end
            end
            StNext: begin
                if (TX_FAIL) begin
                    state_d = StResp;
                end else if (REQ_VALID[grant_q]) begin
                    hold_addr_d = REQ_ADDR[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
                    hold_data_d = REQ_DATA[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                    hold_pend_d = REQ_PEND[grant_q];
                    state_d     = StReqHi;
                end
            end
            StResp: begin
                // FAIL wins when the node reports both at once
                if (TX_FAIL) begin
                    if (!multi_q && (32'(retry_cnt_q) < RETRY_LIMIT)) begin
                        retry_cnt_d = retry_cnt_q + CntW'(1);
                        retry_d     = 1'b1;
                    end else begin
                        req_fail_d = grant_oh_q;
                    end
                    state_d = StClr;
                end else if (TX_SUCC) begin
                    req_done_d = grant_oh_q;
                    state_d    = StClr;
                end
            end
            StClr: begin
                if (!TX_SUCC && !TX_FAIL) begin
                    if (retry_q) begin
                        retry_d = 1'b0;
                        state_d = StReqHi;
                    end else begin
                        rr_ptr_d = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            retry_cnt_q <= '0;
            retry_q     <= 1'b0;
            multi_q     <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            hold_pend_q <= 1'b0;
            req_ack_q   <= '0;
            req_done_q  <= '0;
            req_fail_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            grant_oh_q  <= grant_oh_d;
            retry_cnt_q <= retry_cnt_d;
            retry_q     <= retry_d;
            multi_q     <= multi_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            hold_pend_q <= hold_pend_d;
            req_ack_q   <= req_ack_d;
            req_done_q  <= req_done_d;
            req_fail_q  <= req_fail_d;
        end
    end

    // An early TX_FAIL drops TX_REQ in the same cycle
    assign TX_REQ      = (state_q == StReqHi) && !TX_FAIL;
    assign TX_RESP_ACK = (state_q == StClr);
    assign TX_ADDR     = hold_addr_q;
    assign TX_DATA     = hold_data_q;
    assign TX_PEND     = hold_pend_q;
    assign REQ_ACK     = req_ack_q;
    assign REQ_DONE    = req_done_q;
    assign REQ_FAIL    = req_fail_q;

endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Directed bench for ulpb_tx_arbiter: the bench plays both the requesters and the ulpb node.
module tb_ulpb_tx_arbiter;

    localparam int NR = 4;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [NR-1:0]   REQ_VALID;
    logic [NR*8-1:0] REQ_ADDR;
    logic [NR*32-1:0] REQ_DATA;
    logic [NR-1:0]   REQ_PEND;
    logic [NR-1:0]   REQ_ACK, REQ_DONE, REQ_FAIL;
    logic [7:0]      TX_ADDR;
    logic [31:0]     TX_DATA;
    logic            TX_PEND, TX_REQ, TX_ACK, TX_SUCC, TX_FAIL, TX_RESP_ACK;

    int checks = 0;
    int errors = 0;

    ulpb_tx_arbiter #(
        .NUM_REQ     (NR),
        .RETRY_LIMIT (2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ_VALID   (REQ_VALID),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_DATA    (REQ_DATA),
        .REQ_PEND    (REQ_PEND),
        .REQ_ACK     (REQ_ACK),
        .REQ_DONE    (REQ_DONE),
        .REQ_FAIL    (REQ_FAIL),
        .TX_ADDR     (TX_ADDR),
        .TX_DATA     (TX_DATA),
        .TX_PEND     (TX_PEND),
        .TX_REQ      (TX_REQ),
        .TX_ACK      (TX_ACK),
        .TX_SUCC     (TX_SUCC),
        .TX_FAIL     (TX_FAIL),
        .TX_RESP_ACK (TX_RESP_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [7:0] a, input logic [31:0] d,
                            input logic p);
        REQ_ADDR[i*8 +: 8]   = a;
        REQ_DATA[i*32 +: 32] = d;
        REQ_PEND[i]          = p;
        REQ_VALID[i]         = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (TX_REQ !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_txreq"}, 64'(TX_REQ), 64'd1);
    endtask

    // Wait for TX_REQ, check the presented word, ACK it and check the REQ_ACK pulse.
    task automatic accept(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic p, input logic [NR-1:0] exp_ack);
        wait_req(tag);
        chk({tag, "_addr"}, 64'(TX_ADDR), 64'(a));
        chk({tag, "_data"}, 64'(TX_DATA), 64'(d));
        chk({tag, "_pend"}, 64'(TX_PEND), 64'(p));
        TX_ACK = 1'b1;
        step();
        chk({tag, "_reqack"}, 64'(REQ_ACK), 64'(exp_ack));
        chk({tag, "_reqlo"}, 64'(TX_REQ), 64'd0);
    endtask

    task automatic release_ack(input string tag);
        TX_ACK = 1'b0;
        step();
        chk({tag, "_ackpulse"}, 64'(REQ_ACK), 64'd0);
    endtask

    task automatic resp(input string tag, input logic s, input logic f,
                        input logic [NR-1:0] exp_done, input logic [NR-1:0] exp_fail,
                        input logic hold);
        TX_SUCC = s;
        TX_FAIL = f;
        step();
        chk({tag, "_done"}, 64'(REQ_DONE), 64'(exp_done));
        chk({tag, "_fail"}, 64'(REQ_FAIL), 64'(exp_fail));
        chk({tag, "_respack"}, 64'(TX_RESP_ACK), 64'd1);
        if (hold) begin
            step();
            chk({tag, "_respack_hold"}, 64'(TX_RESP_ACK), 64'd1);
            chk({tag, "_done_once"}, 64'(REQ_DONE | REQ_FAIL), 64'd0);
        end
        TX_SUCC = 1'b0;
        TX_FAIL = 1'b0;
        step();
        chk({tag, "_respack_off"}, 64'(TX_RESP_ACK), 64'd0);
    endtask

    initial begin
        RESET = 1'b1; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; REQ_PEND = '0;
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        step(); step();
        chk("rst_txreq", 64'(TX_REQ), 64'd0);
        chk("rst_pulses", 64'({REQ_ACK, REQ_DONE, REQ_FAIL}), 64'd0);
        chk("rst_hold", 64'({TX_ADDR, TX_DATA, TX_PEND}), 64'd0);
        chk("rst_respack", 64'(TX_RESP_ACK), 64'd0);
        RESET = 1'b0;

        // 1: single word from req0, SUCC held two cycles
        set_word(0, 8'h12, 32'hDEADBEEF, 1'b0);
        accept("t1", 8'h12, 32'hDEADBEEF, 1'b0, 4'b0001);
        REQ_VALID[0] = 1'b0;
        release_ack("t1");
        resp("t1", 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1);

        // req1 message moves rr_ptr from 1 to 2
        set_word(1, 8'h21, 32'h0000_1111, 1'b0);
        accept("t2a", 8'h21, 32'h0000_1111, 1'b0, 4'b0010);
        REQ_VALID[1] = 1'b0;
        release_ack("t2a");
        resp("t2a", 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0);

        // 2: req1 and req3 together with rr_ptr=2 -> req3 first, then req1
        set_word(1, 8'h31, 32'hA1A1_A1A1, 1'b0);
        set_word(3, 8'h33, 32'hA3A3_A3A3, 1'b0);
        accept("t2b", 8'h33, 32'hA3A3_A3A3, 1'b0, 4'b1000);
        REQ_VALID[3] = 1'b0;
        release_ack("t2b");
        resp("t2b", 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0);
        accept("t2c", 8'h31, 32'hA1A1_A1A1, 1'b0, 4'b0010);
        REQ_VALID[1] = 1'b0;
        release_ack("t2c");
        resp("t2c", 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0);

        // 3: req2 three-word message (rr_ptr=2), req0 waiting throughout
        set_word(0, 8'h40, 32'h4000_0000, 1'b0);
        set_word(2, 8'h42, 32'h2222_0001, 1'b1);
        accept("t3w1", 8'h42, 32'h2222_0001, 1'b1, 4'b0100);
        set_word(2, 8'h42, 32'h2222_0002, 1'b1);
        release_ack("t3w1");
        accept("t3w2", 8'h42, 32'h2222_0002, 1'b1, 4'b0100);
        set_word(2, 8'h42, 32'h2222_0003, 1'b0);
        release_ack("t3w2");
        accept("t3w3", 8'h42, 32'h2222_0003, 1'b0, 4'b0100);
        REQ_VALID[2] = 1'b0;
        release_ack("t3w3");
        resp("t3", 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);
        accept("t3r0", 8'h40, 32'h4000_0000, 1'b0, 4'b0001);
        REQ_VALID[0] = 1'b0;
        release_ack("t3r0");
        resp("t3r0", 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);

        // 4: req0 single word failing three times, RETRY_LIMIT=2
        set_word(0, 8'h55, 32'hCAFE_F00D, 1'b0);
        accept("t4s1", 8'h55, 32'hCAFE_F00D, 1'b0, 4'b0001);
        REQ_VALID[0] = 1'b0;
        release_ack("t4s1");
        resp("t4s1", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        accept("t4s2", 8'h55, 32'hCAFE_F00D, 1'b0, 4'b0001);
        release_ack("t4s2");
        resp("t4s2", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        accept("t4s3", 8'h55, 32'hCAFE_F00D, 1'b0, 4'b0001);
        release_ack("t4s3");
        resp("t4s3", 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0);
        step();
        chk("t4_idle", 64'(TX_REQ), 64'd0);

        // 5: req1 multi-word, word 2 withheld, node fails in NEXT
        set_word(1, 8'h66, 32'h6666_0001, 1'b1);
        accept("t5", 8'h66, 32'h6666_0001, 1'b1, 4'b0010);
        REQ_VALID[1] = 1'b0;
        release_ack("t5");
        step();
        chk("t5_next_wait", 64'(TX_REQ), 64'd0);
        TX_FAIL = 1'b1;
        step();
        chk("t5_early_fail", 64'({TX_REQ, REQ_FAIL}), 64'd0);
        resp("t5", 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_retry", 64'(TX_REQ), 64'd0);
        end

        // 6: reset while req2 is in REQ_HI; rr_ptr was 2, after reset req0 must win
        set_word(2, 8'h77, 32'h7777_7777, 1'b0);
        wait_req("t6");
        set_word(0, 8'h70, 32'h7000_0070, 1'b0);
        RESET = 1'b1;
        step();
        chk("t6_txreq", 64'(TX_REQ), 64'd0);
        chk("t6_pulses", 64'({REQ_ACK, REQ_DONE, REQ_FAIL}), 64'd0);
        chk("t6_hold", 64'(TX_ADDR), 64'd0);
        RESET = 1'b0;
        accept("t6r0", 8'h70, 32'h7000_0070, 1'b0, 4'b0001);
        REQ_VALID[0] = 1'b0;
        release_ack("t6r0");
        resp("t6r0", 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
        accept("t6r2", 8'h77, 32'h7777_7777, 1'b0, 4'b0100);
        REQ_VALID[2] = 1'b0;
        release_ack("t6r2");
        resp("t6r2", 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
